// File: rtl/fruit_launcher.sv
// Single-fruit spawner/steerer: picks a pseudo-random launch, applies gravity to vy/dy,
// retires the fruit on slice or screen exit and re-launches it after a moveclk-counted delay.
module fruit_launcher #(
    parameter int          SCREEN_W      = 640,
    parameter int          SCREEN_H      = 480,
    parameter int          SPAWN_Y       = 470,
    parameter int          VY_INIT_MIN   = 8,
    parameter int          VY_MAX        = 15,
    parameter int          GRAVITY_DIV   = 2,
    parameter int          RESPAWN_DELAY = 60,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       moveclk,
    input  logic [9:0] posx,
    input  logic [9:0] posy,
    input  logic       sliced,
    output logic       obj_rst,
    output logic       obj_en,
    output logic [9:0] initPosX,
    output logic [9:0] initPosY,
    output logic [9:0] vx,
    output logic [9:0] vy,
    output logic [1:0] dx,
    output logic [1:0] dy,
    output logic       active,
    output logic       missed
);

    localparam int GW = $clog2(GRAVITY_DIV + 1);
    localparam int DW = $clog2(RESPAWN_DELAY + 1);

    localparam logic [9:0]    SW_L   = 10'(SCREEN_W);
    localparam logic [9:0]    SH_L   = 10'(SCREEN_H);
    localparam logic [9:0]    VYMX_L = 10'(VY_MAX);
    localparam logic [GW-1:0] GLAST  = GW'(GRAVITY_DIV - 1);
    localparam logic [DW-1:0] DLAST  = DW'(RESPAWN_DELAY);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLY_UP, S_FLY_DOWN, S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [9:0]    posx0_q, posx0_d;
    logic [9:0]    vx_q, vx_d;
    logic [9:0]    vy_q, vy_d;
    logic [1:0]    dx_q, dx_d;
    logic [1:0]    dy_q, dy_d;
    logic          missed_q, missed_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          flying;
    logic          retire;

    assign flying = (state_q == S_FLY_UP) || (state_q == S_FLY_DOWN);

    always_comb begin
        state_d  = state_q;
        posx0_d  = posx0_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        gcnt_d   = gcnt_q;
        dcnt_d   = dcnt_q;
        missed_d = 1'b0;
        retire   = 1'b0;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                posx0_d = 10'd64 + {1'b0, lfsr_q[8:0]};
                vx_d    = {8'd0, lfsr_q[10:9]};
                vy_d    = 10'(VY_INIT_MIN) + {7'd0, lfsr_q[13:11]};
                dy_d    = 2'b10;
                if (lfsr_q[10:9] == 2'd0)   dx_d = 2'b00;
                else if (posx0_d < 10'd320) dx_d = 2'b11;
                else                        dx_d = 2'b10;
                gcnt_d  = '0;
                state_d = S_FLY_UP;
            end
            S_FLY_UP, S_FLY_DOWN: begin
                // Exits are checked even while frozen so a slice still lands.
                if (sliced || posx >= SW_L) begin
                    retire = 1'b1;
                end else if (state_q == S_FLY_DOWN && posy >= SH_L) begin
                    retire   = 1'b1;
                    missed_d = 1'b1;
                end else if (en && moveclk) begin
                    if (gcnt_q == GLAST) begin
                        gcnt_d = '0;
                        if (state_q == S_FLY_UP) begin
                            if (vy_q > 10'd1) begin
                                vy_d = vy_q - 10'd1;
                            end else begin
                                dy_d    = 2'b11;
                                state_d = S_FLY_DOWN;
                            end
                        end else if (vy_q < VYMX_L) begin
                            vy_d = vy_q + 10'd1;
                        end
                    end else begin
                        gcnt_d = gcnt_q + GW'(1);
                    end
                end
                if (retire) begin
                    state_d = S_WAIT;
                    dcnt_d  = '0;
                    dy_d    = 2'b00;
                    vy_d    = 10'd0;
                end
            end
            S_WAIT: begin
                if (dcnt_q == DLAST)       state_d = en ? S_LOAD : S_IDLE;
                else if (en && moveclk)    dcnt_d  = dcnt_q + DW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            posx0_q  <= 10'd320;
            vx_q     <= 10'd0;
            vy_q     <= 10'd0;
            dx_q     <= 2'b00;
            dy_q     <= 2'b00;
            missed_q <= 1'b0;
            gcnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            posx0_q  <= posx0_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            missed_q <= missed_d;
            gcnt_q   <= gcnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign obj_rst  = !flying;
    assign obj_en   = en;
    assign active   = flying;
    assign missed   = missed_q;
    assign initPosX = posx0_q;
    assign initPosY = 10'(SPAWN_Y);
    assign vx       = vx_q;
    assign vy       = vy_q;
    assign dx       = dx_q;
    assign dy       = dy_q;

endmodule

// File: tb/tb_fruit_launcher.sv
// Directed bench for fruit_launcher: expectations are queued as stimulus is applied and
// popped against DUT outputs sampled on the falling edge.
module tb_fruit_launcher;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       moveclk = 1'b0;
    logic       sliced = 1'b0;
    logic [9:0] posx = 10'd320;
    logic [9:0] posy = 10'd200;
    logic       obj_rst, obj_en, active, missed;
    logic [9:0] initPosX, initPosY, vx, vy;
    logic [1:0] dx, dy;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    fruit_launcher dut (
        .clk(clk), .rst(rst), .en(en), .moveclk(moveclk),
        .posx(posx), .posy(posy), .sliced(sliced),
        .obj_rst(obj_rst), .obj_en(obj_en),
        .initPosX(initPosX), .initPosY(initPosY),
        .vx(vx), .vy(vy), .dx(dx), .dy(dy),
        .active(active), .missed(missed)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_v(input string t, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %0d, nothing expected", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", t, obs, e);
            end
        end
    endtask

    // Slow motion tick: one pulse then three idle clocks.
    task automatic mpulse();
        moveclk = 1'b1;
        step();
        moveclk = 1'b0;
        repeat (3) step();
    endtask

    task automatic wait_active();
        for (int i = 0; i < 40 && !active; i++) step();
        expect_v("launch_timeout", 1);
        check(32'(active));
    endtask

    task automatic relaunch(input int extra);
        sliced = 1'b1;
        step();
        sliced = 1'b0;
        repeat (extra) step();
        moveclk = 1'b1;
        repeat (60) step();
        moveclk = 1'b0;
        wait_active();
    endtask

    task automatic check_launch();
        logic [1:0] edx;
        edx = (vx == 10'd0) ? 2'b00 : ((initPosX < 10'd320) ? 2'b11 : 2'b10);
        expect_v("launch_objrst", 0);              check(32'(obj_rst));
        expect_v("launch_dy", 2);                  check(32'(dy));
        expect_v("launch_vy_range", 1);            check(32'(vy >= 10'd8 && vy <= 10'd15));
        expect_v("launch_x_range", 1);             check(32'(initPosX >= 10'd64 && initPosX <= 10'd575));
        expect_v("launch_vx_range", 1);            check(32'(vx <= 10'd3));
        expect_v("launch_dx_rule", 32'(edx));      check(32'(dx));
    endtask

    task automatic check_reset();
        expect_v("rst_active", 0);   check(32'(active));
        expect_v("rst_objrst", 1);   check(32'(obj_rst));
        expect_v("rst_vy", 0);       check(32'(vy));
        expect_v("rst_vx", 0);       check(32'(vx));
        expect_v("rst_dy", 0);       check(32'(dy));
        expect_v("rst_dx", 0);       check(32'(dx));
        expect_v("rst_missed", 0);   check(32'(missed));
        expect_v("rst_initx", 320);  check(32'(initPosX));
        expect_v("rst_inity", 470);  check(32'(initPosY));
    endtask

    initial begin
        logic [9:0] first_x;
        logic       diff;
        int         vm, dm, g;
        logic       down;
        logic [9:0] v0;

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        check_reset();

        // First launch: LOAD then FLY_UP
        rst = 1'b1;
        en  = 1'b1;
        step();
        expect_v("load_objrst", 1);  check(32'(obj_rst));
        expect_v("load_active", 0);  check(32'(active));
        step();
        expect_v("fly_active", 1);   check(32'(active));
        check_launch();

        // Twenty relaunches, launch x must vary
        first_x = initPosX;
        diff    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            relaunch(i % 7);
            check_launch();
            if (initPosX != first_x) diff = 1'b1;
        end
        expect_v("x_varies", 1);
        check(32'(diff));

        // Find a launch with vy == 8
        for (int i = 0; i < 150 && vy != 10'd8; i++) relaunch(i % 5);
        expect_v("find_vy8", 8);
        check(32'(vy));

        // Gravity profile with moveclk every 4 clks
        vm = int'(vy); dm = 2; g = 0; down = 1'b0;
        for (int p = 1; p <= 46; p++) begin
            g++;
            if (g == 2) begin
                g = 0;
                if (!down) begin
                    if (vm > 1) vm--;
                    else begin down = 1'b1; dm = 3; end
                end else if (vm < 15) vm++;
            end
            expect_v($sformatf("grav_vy_p%0d", p), 32'(vm));
            expect_v($sformatf("grav_dy_p%0d", p), 32'(dm));
            mpulse();
            check(32'(vy));
            check(32'(dy));
        end

        // Miss off the bottom in FLY_DOWN
        posy = 10'd480;
        step();
        expect_v("miss_pulse", 1);   check(32'(missed));
        expect_v("miss_objrst", 1);  check(32'(obj_rst));
        expect_v("miss_active", 0);  check(32'(active));
        expect_v("miss_vy", 0);      check(32'(vy));
        expect_v("miss_dy", 0);      check(32'(dy));
        posy = 10'd200;
        step();
        expect_v("miss_clear", 0);   check(32'(missed));
        moveclk = 1'b1;
        repeat (59) step();
        moveclk = 1'b0;
        step();
        expect_v("wait_hold_59", 1); check(32'(obj_rst));
        moveclk = 1'b1;
        step();
        moveclk = 1'b0;
        wait_active();
        check_launch();

        // Slice has priority over miss
        moveclk = 1'b1;
        for (int i = 0; i < 40 && dy != 2'b11; i++) step();
        moveclk = 1'b0;
        expect_v("reach_down", 3);   check(32'(dy));
        sliced = 1'b1;
        posy   = 10'd480;
        step();
        sliced = 1'b0;
        expect_v("slice_active", 0); check(32'(active));
        expect_v("slice_missed", 0); check(32'(missed));
        step();
        expect_v("slice_missed2", 0); check(32'(missed));
        posy = 10'd200;

        // Side exit in FLY_UP
        relaunch(0);
        posx = 10'd700;
        step();
        expect_v("side_active", 0);  check(32'(active));
        expect_v("side_missed", 0);  check(32'(missed));
        posx = 10'd320;
        step();
        expect_v("side_missed2", 0); check(32'(missed));

        // Freeze mid-flight with gcnt part-way
        relaunch(0);
        v0 = vy;
        mpulse();
        expect_v("pre_freeze_vy", 32'(v0)); check(32'(vy));
        en = 1'b0;
        step();
        expect_v("freeze_objen", 0); check(32'(obj_en));
        repeat (10) mpulse();
        expect_v("freeze_vy", 32'(v0));  check(32'(vy));
        expect_v("freeze_dy", 2);        check(32'(dy));
        expect_v("freeze_active", 1);    check(32'(active));
        en = 1'b1;
        step();
        expect_v("thaw_objen", 1);       check(32'(obj_en));
        mpulse();
        expect_v("thaw_gcnt_vy", 32'(v0 - 10'd1)); check(32'(vy));

        // Reset mid-flight
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
